// File: rtl/asip_ctrl_pkg.sv
// Shared types and defaults for the vector ASIP pipeline control blocks.
// Used by hazard_scoreboard and pipe_hazard_ctrl.
package asip_ctrl_pkg;

    localparam int unsigned CntBitsDefault = 2;
    localparam int unsigned BrLatDefault   = 2;

    typedef enum logic [1:0] {
        StRun,
        StBrWait,
        StFlush
    } hz_state_t;

    typedef logic [15:0] stall_cnt_t;

    // Saturating increment for the stall statistics counter.
    function automatic stall_cnt_t stall_cnt_sat_inc(input stall_cnt_t v);
        if (v == '1) begin
            return v;
        end
        return v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write counters with issue/retire update and the
// RAW/WAW hazard compare for the instruction sitting in decode.
module hazard_scoreboard
    import asip_ctrl_pkg::*;
#(
    parameter int unsigned SEL_BITS  = 4,
    parameter int unsigned REG_COUNT = 2 ** SEL_BITS,
    parameter int unsigned CNT_BITS  = CntBitsDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_i,
    input  logic                dec_valid_i,
    input  logic [SEL_BITS-1:0] dec_rs1_i,
    input  logic                dec_use1_i,
    input  logic [SEL_BITS-1:0] dec_rs2_i,
    input  logic                dec_use2_i,
    input  logic [SEL_BITS-1:0] dec_rd_i,
    input  logic                dec_regwr_i,
    input  logic                wb_regwr_i,
    input  logic [SEL_BITS-1:0] wb_rd_i,
    output logic                haz_o,
    output logic                issue_o
);

    localparam logic [CNT_BITS-1:0] CntMax = '1;

    logic [CNT_BITS-1:0] pend_q [REG_COUNT];
    logic [CNT_BITS-1:0] pend_d [REG_COUNT];

    logic raw1, raw2, waw_full;
    logic inc_en, dec_en, same_reg;

    always_comb begin
        raw1     = dec_use1_i && (pend_q[dec_rs1_i] != '0);
        raw2     = dec_use2_i && (pend_q[dec_rs2_i] != '0);
        waw_full = dec_regwr_i && (pend_q[dec_rd_i] == CntMax);
        haz_o    = dec_valid_i && run_i && (raw1 || raw2 || waw_full);
        issue_o  = dec_valid_i && run_i && !haz_o;
    end

    always_comb begin
        pend_d   = pend_q;
        inc_en   = issue_o && dec_regwr_i;
        dec_en   = wb_regwr_i && (pend_q[wb_rd_i] != '0);
        same_reg = inc_en && wb_regwr_i && (dec_rd_i == wb_rd_i);
        // A same-register issue and retire cancel out, even on an empty entry.
        if (!same_reg) begin
            if (inc_en) begin
                pend_d[dec_rd_i] = pend_q[dec_rd_i] + CNT_BITS'(1);
            end
            if (dec_en) begin
                pend_d[wb_rd_i] = pend_q[wb_rd_i] - CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/branch controller: scoreboard stalls, branch freeze and wrong-path flush.
// Optional stall statistics counter enabled by PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl
    import asip_ctrl_pkg::*;
#(
    parameter int unsigned SEL_BITS  = 4,
    parameter int unsigned REG_COUNT = 2 ** SEL_BITS,
    parameter int unsigned CNT_BITS  = CntBitsDefault,
    parameter int unsigned BR_LAT    = BrLatDefault
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [SEL_BITS-1:0] dec_rs1,
    input  logic [SEL_BITS-1:0] dec_rs2,
    input  logic                dec_use1,
    input  logic                dec_use2,
    input  logic [SEL_BITS-1:0] dec_rd,
    input  logic                dec_regwr,
    input  logic                dec_pcwr,
    input  logic                wb_regwr,
    input  logic [SEL_BITS-1:0] wb_rd,
    input  logic                br_taken,
    output logic                stall_f,
    output logic                bubble_de,
    output logic                flush_fd,
    output stall_cnt_t          stall_cycles
);

    localparam int unsigned BrCntW = (BR_LAT > 0) ? $clog2(BR_LAT + 1) : 1;

    hz_state_t         state_q;
    logic [BrCntW-1:0] br_cnt_q;
    logic              run;
    logic              haz;
    logic              issue;

    assign run = (state_q == StRun);

    hazard_scoreboard #(
        .SEL_BITS  (SEL_BITS),
        .REG_COUNT (REG_COUNT),
        .CNT_BITS  (CNT_BITS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .run_i       (run),
        .dec_valid_i (dec_valid),
        .dec_rs1_i   (dec_rs1),
        .dec_use1_i  (dec_use1),
        .dec_rs2_i   (dec_rs2),
        .dec_use2_i  (dec_use2),
        .dec_rd_i    (dec_rd),
        .dec_regwr_i (dec_regwr),
        .wb_regwr_i  (wb_regwr),
        .wb_rd_i     (wb_rd),
        .haz_o       (haz),
        .issue_o     (issue)
    );

    // br_taken is only meaningful once the down-counter has drained to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            br_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (issue && dec_pcwr) begin
                        br_cnt_q <= BrCntW'(BR_LAT);
                        state_q  <= StBrWait;
                    end
                end
                StBrWait: begin
                    if (br_cnt_q == '0) begin
                        state_q <= br_taken ? StFlush : StRun;
                    end else begin
                        br_cnt_q <= br_cnt_q - BrCntW'(1);
                    end
                end
                StFlush: begin
                    state_q <= StRun;
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_comb begin
        stall_f   = 1'b0;
        bubble_de = 1'b0;
        flush_fd  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    stall_f   = haz;
                    bubble_de = haz;
                end
                StBrWait: begin
                    stall_f   = 1'b1;
                    bubble_de = 1'b1;
                end
                StFlush: begin
                    bubble_de = 1'b1;
                    flush_fd  = 1'b1;
                end
                default: begin
                    stall_f   = 1'b0;
                    bubble_de = 1'b0;
                    flush_fd  = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    stall_cnt_t stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bubble_de) begin
            stall_cnt_q <= stall_cnt_sat_inc(stall_cnt_q);
        end
    end

    assign stall_cycles = rst ? '0 : stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
